// File: rtl/cmac_tx_arbiter.sv
// Packet-granular two-input round-robin arbiter feeding the CMAC TX AXI-Stream port.
// Grant is held from the first beat to the tlast beat, so packets never interleave.
module cmac_tx_arbiter #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned KEEP_W = DATA_W / 8
) (
  input  logic              cmac_clk,
  input  logic              rst,
  input  logic [1:0]        port_en,

  input  logic              s0_axis_tvalid,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic [KEEP_W-1:0] s0_axis_tkeep,
  input  logic              s0_axis_tlast,
  input  logic              s0_axis_tuser_err,
  output logic              s0_axis_tready,

  input  logic              s1_axis_tvalid,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic [KEEP_W-1:0] s1_axis_tkeep,
  input  logic              s1_axis_tlast,
  input  logic              s1_axis_tuser_err,
  output logic              s1_axis_tready,

  output logic              m_axis_cmac_tvalid,
  output logic [DATA_W-1:0] m_axis_cmac_tdata,
  output logic [KEEP_W-1:0] m_axis_cmac_tkeep,
  output logic              m_axis_cmac_tlast,
  output logic              m_axis_cmac_tuser_err,
  input  logic              m_axis_cmac_tready,

  output logic [1:0]        grant,
  output logic [31:0]       pkt_cnt0,
  output logic [31:0]       pkt_cnt1
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       last_grant_q;
  logic       last_grant_d;
  logic       done0;
  logic       done1;
  logic [1:0] eligible;

  // State register, round-robin pointer and wrapping packet counters
  always_ff @(posedge cmac_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      pkt_cnt0     <= '0;
      pkt_cnt1     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (done0) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (done1) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
    end
  end

  // Grant decision and combinational datapath mux through the current grant
  always_comb begin
    state_d               = state_q;
    last_grant_d          = last_grant_q;
    done0                 = 1'b0;
    done1                 = 1'b0;
    s0_axis_tready        = 1'b0;
    s1_axis_tready        = 1'b0;
    m_axis_cmac_tvalid    = 1'b0;
    m_axis_cmac_tdata     = '0;
    m_axis_cmac_tkeep     = '0;
    m_axis_cmac_tlast     = 1'b0;
    m_axis_cmac_tuser_err = 1'b0;
    eligible              = {s1_axis_tvalid & port_en[1], s0_axis_tvalid & port_en[0]};

    case (state_q)
      IDLE: begin
        if (eligible == 2'b11) begin
          state_d = last_grant_q ? GRANT0 : GRANT1;
        end else if (eligible[0]) begin
          state_d = GRANT0;
        end else if (eligible[1]) begin
          state_d = GRANT1;
        end
      end

      GRANT0: begin
        m_axis_cmac_tvalid    = s0_axis_tvalid;
        m_axis_cmac_tdata     = s0_axis_tdata;
        m_axis_cmac_tkeep     = s0_axis_tkeep;
        m_axis_cmac_tlast     = s0_axis_tlast;
        m_axis_cmac_tuser_err = s0_axis_tuser_err;
        s0_axis_tready        = m_axis_cmac_tready;
        done0                 = s0_axis_tvalid & m_axis_cmac_tready & s0_axis_tlast;
        if (done0) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end

      GRANT1: begin
        m_axis_cmac_tvalid    = s1_axis_tvalid;
        m_axis_cmac_tdata     = s1_axis_tdata;
        m_axis_cmac_tkeep     = s1_axis_tkeep;
        m_axis_cmac_tlast     = s1_axis_tlast;
        m_axis_cmac_tuser_err = s1_axis_tuser_err;
        s1_axis_tready        = m_axis_cmac_tready;
        done1                 = s1_axis_tvalid & m_axis_cmac_tready & s1_axis_tlast;
        if (done1) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // One-hot grant decoded straight from the state flops
  assign grant = {state_q == GRANT1, state_q == GRANT0};

endmodule

// File: tb/tb_cmac_tx_arbiter.sv
// Self-checking bench for cmac_tx_arbiter: per-cycle vector table plus directed
// sequences for backpressure, enables, reset mid-packet and counter wrap.
module tb_cmac_tx_arbiter;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned NVEC   = 21;

  logic              clk;
  logic              rst;
  logic [1:0]        port_en;
  logic              s0_tvalid, s0_tlast, s0_err, s0_tready;
  logic [DATA_W-1:0] s0_tdata;
  logic [KEEP_W-1:0] s0_tkeep;
  logic              s1_tvalid, s1_tlast, s1_err, s1_tready;
  logic [DATA_W-1:0] s1_tdata;
  logic [KEEP_W-1:0] s1_tkeep;
  logic              m_tvalid, m_tlast, m_err, m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic [KEEP_W-1:0] m_tkeep;
  logic [1:0]        grant;
  logic [31:0]       pkt_cnt0, pkt_cnt1;

  int pass_cnt  = 0;
  int check_cnt = 0;

  cmac_tx_arbiter #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
    .cmac_clk              (clk),
    .rst                   (rst),
    .port_en               (port_en),
    .s0_axis_tvalid        (s0_tvalid),
    .s0_axis_tdata         (s0_tdata),
    .s0_axis_tkeep         (s0_tkeep),
    .s0_axis_tlast         (s0_tlast),
    .s0_axis_tuser_err     (s0_err),
    .s0_axis_tready        (s0_tready),
    .s1_axis_tvalid        (s1_tvalid),
    .s1_axis_tdata         (s1_tdata),
    .s1_axis_tkeep         (s1_tkeep),
    .s1_axis_tlast         (s1_tlast),
    .s1_axis_tuser_err     (s1_err),
    .s1_axis_tready        (s1_tready),
    .m_axis_cmac_tvalid    (m_tvalid),
    .m_axis_cmac_tdata     (m_tdata),
    .m_axis_cmac_tkeep     (m_tkeep),
    .m_axis_cmac_tlast     (m_tlast),
    .m_axis_cmac_tuser_err (m_err),
    .m_axis_cmac_tready    (m_tready),
    .grant                 (grant),
    .pkt_cnt0              (pkt_cnt0),
    .pkt_cnt1              (pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of inputs and the outputs expected during that same cycle
  typedef struct packed {
    logic        rst;
    logic [1:0]  en;
    logic        v0;
    logic [63:0] d0;
    logic        l0;
    logic        v1;
    logic [63:0] d1;
    logic        l1;
    logic        mr;
    logic [1:0]  g;
    logic        mv;
    logic [63:0] md;
    logic        ml;
    logic        r0;
    logic        r1;
    logic [31:0] c0;
    logic [31:0] c1;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [KEEP_W-1:0] exp_keep;
    rst       = v.rst;
    port_en   = v.en;
    s0_tvalid = v.v0;
    s0_tdata  = v.d0;
    s0_tlast  = v.l0;
    s1_tvalid = v.v1;
    s1_tdata  = v.d1;
    s1_tlast  = v.l1;
    m_tready  = v.mr;
    #1;
    exp_keep = v.mv ? (v.g[0] ? 8'hFF : 8'h0F) : 8'h00;
    chk($sformatf("vec%0d grant", i), 64'(grant), 64'(v.g));
    chk($sformatf("vec%0d m_tvalid", i), 64'(m_tvalid), 64'(v.mv));
    chk($sformatf("vec%0d m_tdata", i), m_tdata, v.md);
    chk($sformatf("vec%0d m_tkeep", i), 64'(m_tkeep), 64'(exp_keep));
    chk($sformatf("vec%0d m_tlast", i), 64'(m_tlast), 64'(v.ml));
    chk($sformatf("vec%0d m_err", i), 64'(m_err), 64'd0);
    chk($sformatf("vec%0d s0_tready", i), 64'(s0_tready), 64'(v.r0));
    chk($sformatf("vec%0d s1_tready", i), 64'(s1_tready), 64'(v.r1));
    chk($sformatf("vec%0d pkt_cnt0", i), 64'(pkt_cnt0), 64'(v.c0));
    chk($sformatf("vec%0d pkt_cnt1", i), 64'(pkt_cnt1), 64'(v.c1));
    tick();
  endtask

  initial begin
    // Single 4-beat s0 packet, then reset and contention between 2-beat packets
    //            rst   en     v0    d0      l0    v1    d1      l1    mr    g      mv    md      ml    r0    r1    c0     c1
    vecs[0]  = '{1'b1, 2'b11, 1'b0, 64'h00, 1'b0, 1'b0, 64'h00, 1'b0, 1'b1, 2'b00, 1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[1]  = '{1'b0, 2'b11, 1'b1, 64'hA0, 1'b0, 1'b0, 64'h00, 1'b0, 1'b1, 2'b00, 1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[2]  = '{1'b0, 2'b11, 1'b1, 64'hA0, 1'b0, 1'b0, 64'h00, 1'b0, 1'b1, 2'b01, 1'b1, 64'hA0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0};
    vecs[3]  = '{1'b0, 2'b11, 1'b1, 64'hA1, 1'b0, 1'b0, 64'h00, 1'b0, 1'b1, 2'b01, 1'b1, 64'hA1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0};
    vecs[4]  = '{1'b0, 2'b11, 1'b1, 64'hA2, 1'b0, 1'b0, 64'h00, 1'b0, 1'b1, 2'b01, 1'b1, 64'hA2, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0};
    vecs[5]  = '{1'b0, 2'b11, 1'b1, 64'hA3, 1'b1, 1'b0, 64'h00, 1'b0, 1'b1, 2'b01, 1'b1, 64'hA3, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0};
    vecs[6]  = '{1'b0, 2'b11, 1'b0, 64'h00, 1'b0, 1'b0, 64'h00, 1'b0, 1'b1, 2'b00, 1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0};
    vecs[7]  = '{1'b1, 2'b11, 1'b0, 64'h00, 1'b0, 1'b0, 64'h00, 1'b0, 1'b1, 2'b00, 1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0};
    vecs[8]  = '{1'b0, 2'b11, 1'b1, 64'hC0, 1'b0, 1'b1, 64'hD0, 1'b0, 1'b1, 2'b00, 1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[9]  = '{1'b0, 2'b11, 1'b1, 64'hC0, 1'b0, 1'b1, 64'hD0, 1'b0, 1'b1, 2'b01, 1'b1, 64'hC0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0};
    vecs[10] = '{1'b0, 2'b11, 1'b1, 64'hC1, 1'b1, 1'b1, 64'hD0, 1'b0, 1'b1, 2'b01, 1'b1, 64'hC1, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0};
    vecs[11] = '{1'b0, 2'b11, 1'b1, 64'hC2, 1'b0, 1'b1, 64'hD0, 1'b0, 1'b1, 2'b00, 1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0};
    vecs[12] = '{1'b0, 2'b11, 1'b1, 64'hC2, 1'b0, 1'b1, 64'hD0, 1'b0, 1'b1, 2'b10, 1'b1, 64'hD0, 1'b0, 1'b0, 1'b1, 32'd1, 32'd0};
    vecs[13] = '{1'b0, 2'b11, 1'b1, 64'hC2, 1'b0, 1'b1, 64'hD1, 1'b1, 1'b1, 2'b10, 1'b1, 64'hD1, 1'b1, 1'b0, 1'b1, 32'd1, 32'd0};
    vecs[14] = '{1'b0, 2'b11, 1'b1, 64'hC2, 1'b0, 1'b1, 64'hD2, 1'b0, 1'b1, 2'b00, 1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1};
    vecs[15] = '{1'b0, 2'b11, 1'b1, 64'hC2, 1'b0, 1'b1, 64'hD2, 1'b0, 1'b1, 2'b01, 1'b1, 64'hC2, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1};
    vecs[16] = '{1'b0, 2'b11, 1'b1, 64'hC3, 1'b1, 1'b1, 64'hD2, 1'b0, 1'b1, 2'b01, 1'b1, 64'hC3, 1'b1, 1'b1, 1'b0, 32'd1, 32'd1};
    vecs[17] = '{1'b0, 2'b11, 1'b0, 64'h00, 1'b0, 1'b1, 64'hD2, 1'b0, 1'b1, 2'b00, 1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 32'd2, 32'd1};
    vecs[18] = '{1'b0, 2'b11, 1'b0, 64'h00, 1'b0, 1'b1, 64'hD2, 1'b0, 1'b1, 2'b10, 1'b1, 64'hD2, 1'b0, 1'b0, 1'b1, 32'd2, 32'd1};
    vecs[19] = '{1'b0, 2'b11, 1'b0, 64'h00, 1'b0, 1'b1, 64'hD3, 1'b1, 1'b1, 2'b10, 1'b1, 64'hD3, 1'b1, 1'b0, 1'b1, 32'd2, 32'd1};
    vecs[20] = '{1'b0, 2'b11, 1'b0, 64'h00, 1'b0, 1'b0, 64'h00, 1'b0, 1'b1, 2'b00, 1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 32'd2, 32'd2};

    rst = 1'b1; port_en = 2'b11; m_tready = 1'b1;
    s0_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = 8'hFF; s0_tlast = 1'b0; s0_err = 1'b0;
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = 8'h0F; s1_tlast = 1'b0; s1_err = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < int'(NVEC); i++) run_vec(i, vecs[i]);

    // Backpressure: 3-beat s1 packet with ready alternating
    rst = 1'b0; port_en = 2'b11; m_tready = 1'b1;
    s1_tvalid = 1'b1; s1_tdata = 64'hE0; s1_tlast = 1'b0; #1;
    chk("bp idle grant", 64'(grant), 64'd0);
    tick(); #1;
    chk("bp b0 grant", 64'(grant), 64'd2);
    chk("bp b0 data", m_tdata, 64'hE0);
    chk("bp b0 ready", 64'(s1_tready), 64'd1);
    tick(); s1_tdata = 64'hE1; m_tready = 1'b0; #1;
    chk("bp b1 stall valid", 64'(m_tvalid), 64'd1);
    chk("bp b1 stall ready", 64'(s1_tready), 64'd0);
    chk("bp b1 stall grant", 64'(grant), 64'd2);
    tick(); m_tready = 1'b1; #1;
    chk("bp b1 data held", m_tdata, 64'hE1);
    chk("bp b1 ready", 64'(s1_tready), 64'd1);
    tick(); s1_tdata = 64'hE2; s1_tlast = 1'b1; m_tready = 1'b0; #1;
    chk("bp b2 stall grant", 64'(grant), 64'd2);
    chk("bp b2 stall last", 64'(m_tlast), 64'd1);
    tick(); m_tready = 1'b1; #1;
    chk("bp b2 grant", 64'(grant), 64'd2);
    chk("bp b2 data", m_tdata, 64'hE2);
    chk("bp b2 cnt1 before", 64'(pkt_cnt1), 64'd2);
    tick(); s1_tvalid = 1'b0; s1_tlast = 1'b0; #1;
    chk("bp done grant", 64'(grant), 64'd0);
    chk("bp done cnt1", 64'(pkt_cnt1), 64'd3);

    // Enables: only s1 eligible; clearing port_en[1] mid-packet lets it finish
    port_en = 2'b10;
    s0_tvalid = 1'b1; s0_tdata = 64'hF0; s0_tlast = 1'b1;
    s1_tvalid = 1'b1; s1_tdata = 64'h60; s1_tlast = 1'b0; #1;
    chk("en idle s0_tready", 64'(s0_tready), 64'd0);
    tick(); #1;
    chk("en b0 grant", 64'(grant), 64'd2);
    chk("en b0 data", m_tdata, 64'h60);
    chk("en b0 s0_tready", 64'(s0_tready), 64'd0);
    tick(); port_en = 2'b00; s1_tdata = 64'h61; s1_tlast = 1'b1; #1;
    chk("en b1 grant", 64'(grant), 64'd2);
    chk("en b1 data", m_tdata, 64'h61);
    chk("en b1 s1_tready", 64'(s1_tready), 64'd1);
    tick(); s1_tvalid = 1'b0; s1_tlast = 1'b0; #1;
    chk("en after grant", 64'(grant), 64'd0);
    chk("en after cnt1", 64'(pkt_cnt1), 64'd4);
    tick(); #1;
    chk("en disabled grant", 64'(grant), 64'd0);
    chk("en disabled s0_tready", 64'(s0_tready), 64'd0);
    chk("en disabled cnt0", 64'(pkt_cnt0), 64'd2);
    s0_tvalid = 1'b0; s0_tlast = 1'b0;

    // Reset after beat 2 of a 5-beat s0 packet
    tick(); port_en = 2'b11;
    s0_tvalid = 1'b1; s0_tdata = 64'h70; s0_tlast = 1'b0; #1;
    chk("rst idle grant", 64'(grant), 64'd0);
    tick(); #1;
    chk("rst b0 data", m_tdata, 64'h70);
    tick(); s0_tdata = 64'h71; #1;
    chk("rst b1 data", m_tdata, 64'h71);
    tick(); s0_tdata = 64'h72; rst = 1'b1; #1;
    tick(); rst = 1'b0; s0_tvalid = 1'b0; #1;
    chk("rst m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst grant", 64'(grant), 64'd0);
    chk("rst m_tlast", 64'(m_tlast), 64'd0);
    chk("rst cnt0", 64'(pkt_cnt0), 64'd0);
    chk("rst cnt1", 64'(pkt_cnt1), 64'd0);
    chk("rst s0_tready", 64'(s0_tready), 64'd0);

    // Counter wrap on an errored single-beat s1 packet
    tick();
    force dut.pkt_cnt1 = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt1;
    #1;
    chk("wrap preload", 64'(pkt_cnt1), 64'hFFFF_FFFF);
    s1_tvalid = 1'b1; s1_tdata = 64'h99; s1_tlast = 1'b1; s1_err = 1'b1; #1;
    chk("wrap idle err", 64'(m_err), 64'd0);
    tick(); #1;
    chk("wrap grant", 64'(grant), 64'd2);
    chk("wrap m_err", 64'(m_err), 64'd1);
    chk("wrap m_tlast", 64'(m_tlast), 64'd1);
    chk("wrap cnt1 before", 64'(pkt_cnt1), 64'hFFFF_FFFF);
    tick(); s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_err = 1'b0; #1;
    chk("wrap cnt1", 64'(pkt_cnt1), 64'd0);
    chk("wrap done grant", 64'(grant), 64'd0);
    chk("wrap cnt0", 64'(pkt_cnt0), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
